map_ss_seq: RTL and testbench
=============================

MAP_SS_SEQ -- requirements
Module: map_ss_seq

Interface
REQ-001 SHALL have parameter LAST_ADDR, default 127, highest save-state register index transferred.
REQ-002 SHALL have parameter TMO, default 255, max clk cycles waited for an m2 falling-edge strobe.
REQ-003 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-004 SHALL have ports: rst  in  1  synchronous active-high reset.
REQ-005 SHALL have ports: start  in  1  one-cycle request to begin a transfer, sampled only in IDLE.
REQ-006 SHALL have ports: dir  in  1  0 = save (mapper -> host), 1 = restore (host -> mapper), sampled with start.
REQ-007 SHALL have ports: m2_fall  in  1  one-cycle strobe, CPU M2 falling edge already synchronised to clk.
REQ-008 SHALL have ports: ss_act  out  1, ss_we  out  1, ss_addr  out  8, ss_wdat  out  8  mapper save-state control bus.
REQ-009 SHALL have ports: ss_rdat  in  8  mapper save-state read data, valid combinationally from ss_addr.
REQ-010 SHALL have ports: in_valid in 1, in_data in 8, in_ready out 1  host restore byte stream.
REQ-011 SHALL have ports: out_valid out 1, out_data out 8, out_ready in 1  host save byte stream.
REQ-012 SHALL have ports: busy out 1, done out 1 (one-cycle pulse), err out 1 (sticky until next start or rst).

Function
REQ-013 SHALL implement states IDLE, ARM, RD, SEND, GETB, HOLD, NEXT, FIN.
REQ-014 IDLE: start=1 -> ARM, clear err, ss_addr<=0, latch dir; start ignored in every other state.
REQ-015 ARM: assert ss_act, wait for m2_fall; on m2_fall -> RD (dir=0) or GETB (dir=1); ss_act stays high until FIN.
REQ-016 RD: capture ss_rdat into out_data one cycle after ss_addr is stable, then go to SEND.
REQ-017 SEND: out_valid=1, out_data held constant; transfer on out_valid&out_ready, then go to NEXT; no timeout applies.
REQ-018 GETB: in_ready=1; on in_valid&in_ready latch in_data into ss_wdat, then go to HOLD; in_ready=0 in all other states.
REQ-019 HOLD: ss_we=1 with ss_addr and ss_wdat stable until the first m2_fall, then ss_we<=0 on the next cycle, then go to NEXT; this guarantees the mapper samples on a negedge m2.
REQ-020 Restore at ss_addr==127: no ss_we; compare in_data with ss_rdat; on mismatch set err and go to FIN immediately, with no further bytes consumed.
REQ-021 NEXT: if ss_addr==LAST_ADDR -> FIN, otherwise ss_addr<=ss_addr+1 and go to RD or GETB.
REQ-022 FIN: ss_act<=0, done=1 for exactly one cycle, then go to IDLE.
REQ-023 Timeout: an 8-bit counter runs in ARM and HOLD, cleared on state entry. Reaching TMO sets err, forces ss_we=0, and goes to FIN.
REQ-024 busy SHALL equal (state!=IDLE).
REQ-025 ss_we SHALL never be 1 while ss_act=0, and never 1 when dir=0.
REQ-026 When m2_fall and in_valid coincide in GETB, the byte SHALL be accepted; the strobe SHALL NOT count toward HOLD.
REQ-027 Total bytes transferred SHALL be LAST_ADDR+1 on success, fewer only on err.

Reset
REQ-028 On rst=1 the block SHALL set: state=IDLE, ss_act=0, ss_we=0, ss_addr=0, ss_wdat=0, out_valid=0, out_data=0, in_ready=0, busy=0, done=0, err=0, timeout counter=0.
REQ-029 rst mid-transfer SHALL abort on the next edge with no done pulse. ss_we SHALL drop in the same cycle as reset takes effect.

Verification
REQ-030 Save, LAST_ADDR=1, ss_rdat = {0x5A, 0x77}, out_ready=1, m2_fall every 6 cycles -> out bytes 0x5A, 0x77, then done pulse, err=0, ss_we never high.
REQ-031 Restore, LAST_ADDR=0, in_data 0x3C -> ss_we high with ss_addr=0 and ss_wdat=0x3C across exactly one m2_fall, then done.
REQ-032 Restore reaching addr 127 with in_data=0x05 and ss_rdat=0x4D -> err=1, done pulse, in_ready low afterwards, byte count 128.
REQ-033 No m2_fall for 255 cycles while in HOLD -> err=1, ss_we=0, done pulse, state IDLE.
REQ-034 Save with out_ready=0 for 40 cycles at addr 3 -> out_valid held, out_data stable, no timeout, resumes when out_ready=1.
REQ-035 rst asserted in HOLD -> next cycle ss_we=0, ss_act=0, busy=0, no done pulse. A fresh start then completes normally.

Source files
------------

// File: rtl/map_ss_seq_if.sv
// Save-state sequencer bus bundle: mapper save-state port plus the two host byte streams.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready and out_valid/out_ready are plain valid-ready pairs.
// Ports (signals):
//   ss_act, ss_we, ss_addr[7:0], ss_wdat[7:0]  sequencer -> mapper control
//   ss_rdat[7:0]                               mapper -> sequencer read data (combinational from ss_addr)
//   in_valid, in_data[7:0] / in_ready          host -> sequencer restore stream
//   out_valid, out_data[7:0] / out_ready       sequencer -> host save stream
// Modport master is the sequencer's view, slave is the environment's view.
interface map_ss_seq_if;
  logic       ss_act;
  logic       ss_we;
  logic [7:0] ss_addr;
  logic [7:0] ss_wdat;
  logic [7:0] ss_rdat;

  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  modport master (
    output ss_act, ss_we, ss_addr, ss_wdat,
    input  ss_rdat,
    input  in_valid, in_data,
    output in_ready,
    output out_valid, out_data,
    input  out_ready
  );

  modport slave (
    input  ss_act, ss_we, ss_addr, ss_wdat,
    output ss_rdat,
    output in_valid, in_data,
    input  in_ready,
    input  out_valid, out_data,
    output out_ready
  );
endinterface

// File: rtl/map_ss_seq.sv
// Mapper save-state sequencer: streams registers 0..LAST_ADDR out (save) or in (restore).
// Latency: one byte per RD+SEND+NEXT (save) or GETB+HOLD+NEXT (restore); first byte waits for M2.
// Backpressure: SEND stalls indefinitely on out_ready; GETB stalls on in_valid; ARM/HOLD time out.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start, dir      one-cycle request in IDLE; dir 0 = save, 1 = restore
//   m2_fall         synchronised CPU M2 falling-edge strobe
//   bus (master)    mapper save-state bus and host byte streams
//   busy, done, err state != IDLE, one-cycle completion pulse, sticky error
module map_ss_seq #(
  parameter int LAST_ADDR = 127,
  parameter int TMO       = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         dir,
  input  logic         m2_fall,
  map_ss_seq_if.master bus,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {
    IDLE, ARM, RD, SEND, GETB, HOLD, NEXT, FIN
  } state_t;

  localparam logic [7:0] LAST     = 8'(LAST_ADDR);
  // Counter value on the cycle that would complete TMO waiting cycles.
  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);
  // Register 127 carries a check byte on restore: compared, never written.
  localparam logic [7:0] CHK_ADDR = 8'd127;

  state_t     state;
  logic       dir_q;
  logic [7:0] tmo_cnt;
  logic       tmo_hit;

  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      dir_q         <= 1'b0;
      tmo_cnt       <= 8'd0;
      bus.ss_act    <= 1'b0;
      bus.ss_we     <= 1'b0;
      bus.ss_addr   <= 8'd0;
      bus.ss_wdat   <= 8'd0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= 8'd0;
      bus.in_ready  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= ARM;
            busy        <= 1'b1;
            bus.ss_act  <= 1'b1;
            err         <= 1'b0;
            bus.ss_addr <= 8'd0;
            dir_q       <= dir;
            tmo_cnt     <= 8'd0;
          end
        end

        ARM: begin
          if (m2_fall) begin
            tmo_cnt <= 8'd0;
            if (dir_q) begin
              bus.in_ready <= 1'b1;
              state        <= GETB;
            end else begin
              state <= RD;
            end
          end else if (tmo_hit) begin
            err        <= 1'b1;
            bus.ss_act <= 1'b0;
            done       <= 1'b1;
            state      <= FIN;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        // ss_addr has been stable for a full cycle, so ss_rdat is settled.
        RD: begin
          bus.out_data  <= bus.ss_rdat;
          bus.out_valid <= 1'b1;
          state         <= SEND;
        end

        SEND: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= NEXT;
          end
        end

        // A coincident m2_fall here is deliberately ignored: HOLD must see
        // a strobe that arrives while ss_we is already high.
        GETB: begin
          if (bus.in_valid && bus.in_ready) begin
            bus.in_ready <= 1'b0;
            if (bus.ss_addr == CHK_ADDR) begin
              if (bus.in_data != bus.ss_rdat) begin
                err        <= 1'b1;
                bus.ss_act <= 1'b0;
                done       <= 1'b1;
                state      <= FIN;
              end else begin
                state <= NEXT;
              end
            end else begin
              bus.ss_wdat <= bus.in_data;
              bus.ss_we   <= 1'b1;
              tmo_cnt     <= 8'd0;
              state       <= HOLD;
            end
          end
        end

        // Keep the write request up across one M2 falling edge so the
        // mapper latches it on its own negedge.
        HOLD: begin
          if (m2_fall) begin
            bus.ss_we <= 1'b0;
            state     <= NEXT;
          end else if (tmo_hit) begin
            bus.ss_we  <= 1'b0;
            err        <= 1'b1;
            bus.ss_act <= 1'b0;
            done       <= 1'b1;
            state      <= FIN;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        NEXT: begin
          if (bus.ss_addr == LAST) begin
            bus.ss_act <= 1'b0;
            done       <= 1'b1;
            state      <= FIN;
          end else begin
            bus.ss_addr <= bus.ss_addr + 8'd1;
            if (dir_q) begin
              bus.in_ready <= 1'b1;
              state        <= GETB;
            end else begin
              state <= RD;
            end
          end
        end

        // done is high for this single cycle.
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_map_ss_seq.sv
// Self-checking bench for map_ss_seq: directed scenarios with randomized data,
// handshake timing and M2 period, checked against a simple register-file model.
module tb_map_ss_seq;

  localparam int LAST = 127;
  localparam int TMO  = 255;

  logic clk = 1'b0;
  logic rst, start, dir, m2_fall;
  logic busy, done, err;

  map_ss_seq_if bus ();

  map_ss_seq #(.LAST_ADDR(LAST), .TMO(TMO)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .dir     (dir),
    .m2_fall (m2_fall),
    .bus     (bus.master),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Mapper save-state register file.
  logic [7:0] mem [256];
  assign bus.ss_rdat = mem[bus.ss_addr];

  int tests_run, tests_failed;

  // Stimulus controls.
  logic [7:0] in_q [$];
  logic [7:0] out_q [$];
  int   rdy_mode;   // 0 random, 1 always ready, 2 random but stall at address 3
  logic m2_en, m2_kick;
  int   m2_per, m2_ph;
  logic cur_dir;
  logic hs;

  // Monitor statistics.
  int   in_cnt, we_strobes, we0_strobes, we_viol, done_cnt, done_long, hold_viol;
  logic [7:0] we0_dat;
  logic prev_we_strobe, prev_done, prev_stall;
  logic [7:0] prev_od;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    in_cnt = 0; we_strobes = 0; we0_strobes = 0; we_viol = 0;
    done_cnt = 0; done_long = 0; hold_viol = 0; we0_dat = 8'h00;
    out_q.delete();
  endtask

  task automatic do_start(input logic d);
    @(negedge clk);
    cur_dir = d; dir = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0; dir = 1'($urandom);
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  function automatic logic [31:0] q_at(input int i);
    if (i < out_q.size()) return {24'd0, out_q[i]};
    return 32'hDEAD_BEEF;
  endfunction

  // M2 strobe: free-running with period m2_per, or a single manual kick.
  initial begin
    m2_fall = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (m2_kick) begin
        m2_fall = 1'b1; m2_kick = 1'b0;
      end else if (m2_en && m2_ph >= m2_per - 1) begin
        m2_fall = 1'b1; m2_ph = 0;
      end else begin
        m2_fall = 1'b0;
        if (m2_en) m2_ph++;
      end
    end
  end

  // Host save-stream sink.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1: bus.out_ready = 1'b1;
        2: bus.out_ready = (bus.out_valid && bus.ss_addr == 8'd3) ? 1'b0 : 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Host restore-stream source: valid held until accepted, random gaps.
  initial begin
    bus.in_valid = 1'b0; bus.in_data = 8'h00; hs = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (hs && in_q.size() > 0) begin
        void'(in_q.pop_front());
        bus.in_valid = 1'b0;
      end
      if (in_q.size() == 0) bus.in_valid = 1'b0;
      else if (!bus.in_valid && $urandom_range(0, 2) != 0) bus.in_valid = 1'b1;
      bus.in_data = (in_q.size() > 0) ? in_q[0] : 8'h00;
      #2;
      hs = bus.in_valid && bus.in_ready;
    end
  end

  // Monitor, sampled just before each rising edge; also models the mapper
  // latching ss_wdat on an M2 falling edge while ss_we is up.
  initial begin
    prev_we_strobe = 1'b0; prev_done = 1'b0; prev_stall = 1'b0; prev_od = 8'h00;
    forever begin
      @(posedge clk); #3;
      if (bus.out_valid && bus.out_ready) out_q.push_back(bus.out_data);
      if (bus.in_valid && bus.in_ready) in_cnt++;
      if (bus.ss_we && (!bus.ss_act || !cur_dir)) we_viol++;
      if (prev_we_strobe && bus.ss_we) we_viol++;
      if (bus.ss_we && m2_fall && !rst) begin
        we_strobes++;
        mem[bus.ss_addr] = bus.ss_wdat;
        if (bus.ss_addr == 8'd0) begin
          we0_strobes++;
          we0_dat = bus.ss_wdat;
        end
      end
      prev_we_strobe = bus.ss_we && m2_fall;
      if (done) begin
        done_cnt++;
        if (prev_done) done_long++;
      end
      prev_done = done;
      if (prev_stall && (!bus.out_valid || bus.out_data != prev_od)) hold_viol++;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_od    = bus.out_data;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_q [$];
    logic [7:0] b [128];
    logic [7:0] m127;
    int cyc, bad;

    tests_run = 0; tests_failed = 0;
    rst = 1'b1; start = 1'b0; dir = 1'b0; cur_dir = 1'b0;
    rdy_mode = 1; m2_en = 1'b0; m2_kick = 1'b0; m2_per = 6; m2_ph = 0;
    clr_stats();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy",   {31'd0, busy}, 0);
    check("rst_done",   {31'd0, done}, 0);
    check("rst_err",    {31'd0, err}, 0);
    check("rst_act",    {31'd0, bus.ss_act}, 0);
    check("rst_we",     {31'd0, bus.ss_we}, 0);
    check("rst_addr",   {24'd0, bus.ss_addr}, 0);
    check("rst_wdat",   {24'd0, bus.ss_wdat}, 0);
    check("rst_ovalid", {31'd0, bus.out_valid}, 0);
    check("rst_odata",  {24'd0, bus.out_data}, 0);
    check("rst_iready", {31'd0, bus.in_ready}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Save, always ready, M2 every 6 cycles.
    mem[0] = 8'h5A; mem[1] = 8'h77;
    exp_q.delete();
    for (int i = 0; i <= LAST; i++) exp_q.push_back(mem[i]);
    m2_per = 6; m2_en = 1'b1; rdy_mode = 1;
    clr_stats();
    do_start(1'b0);
    check("save_busy", {31'd0, busy}, 1);
    check("save_act",  {31'd0, bus.ss_act}, 1);
    wait_done(3000, cyc);
    check("save_err_at_done", {31'd0, err}, 0);
    @(negedge clk);
    check("save_byte0", q_at(0), 32'h5A);
    check("save_byte1", q_at(1), 32'h77);
    check("save_count", out_q.size(), LAST + 1);
    bad = 0;
    for (int i = 0; i <= LAST; i++) if (q_at(i) !== {24'd0, exp_q[i]}) bad++;
    check("save_stream", bad, 0);
    check("save_we_never", we_strobes + we_viol, 0);
    check("save_done_once", done_cnt, 1);
    check("save_done_width", done_long, 0);
    check("save_idle_busy", {31'd0, busy}, 0);
    check("save_idle_act",  {31'd0, bus.ss_act}, 0);

    // Restore, all registers, check byte matches.
    for (int i = 0; i < 128; i++) b[i] = 8'($urandom);
    b[0] = 8'h3C;
    m127 = mem[127];
    b[127] = m127;
    for (int i = 0; i < 128; i++) in_q.push_back(b[i]);
    m2_per = $urandom_range(4, 9);
    clr_stats();
    do_start(1'b1);
    wait_done(8000, cyc);
    @(negedge clk);
    check("rest_err", {31'd0, err}, 0);
    check("rest_in_count", in_cnt, 128);
    check("rest_writes", we_strobes, 127);
    check("rest_addr0_strobes", we0_strobes, 1);
    check("rest_addr0_wdat", {24'd0, we0_dat}, 32'h3C);
    bad = 0;
    for (int i = 0; i < 127; i++) if (mem[i] !== b[i]) bad++;
    check("rest_mem", bad, 0);
    check("rest_mem127", {24'd0, mem[127]}, {24'd0, m127});
    check("rest_we_rules", we_viol, 0);
    check("rest_done_once", done_cnt, 1);
    check("rest_in_ready", {31'd0, bus.in_ready}, 0);

    // Restore with check-byte mismatch; an extra byte must stay unconsumed.
    for (int i = 0; i < 128; i++) b[i] = 8'($urandom);
    mem[127] = 8'h4D;
    b[127] = 8'h05;
    for (int i = 0; i < 128; i++) in_q.push_back(b[i]);
    in_q.push_back(8'hEE);
    clr_stats();
    do_start(1'b1);
    wait_done(8000, cyc);
    check("chk_err", {31'd0, err}, 1);
    @(negedge clk);
    check("chk_in_count", in_cnt, 128);
    check("chk_left", in_q.size(), 1);
    check("chk_writes", we_strobes, 127);
    check("chk_done_once", done_cnt, 1);
    check("chk_busy", {31'd0, busy}, 0);
    repeat (5) @(negedge clk);
    check("chk_err_sticky", {31'd0, err}, 1);
    check("chk_in_ready", {31'd0, bus.in_ready}, 0);
    check("chk_in_count_late", in_cnt, 128);
    in_q.delete();
    @(negedge clk);

    // HOLD timeout: one M2 kick to leave ARM, then silence.
    m2_en = 1'b0;
    in_q.push_back(8'($urandom)); in_q.push_back(8'($urandom));
    clr_stats();
    do_start(1'b1);
    check("tmo_err_cleared", {31'd0, err}, 0);
    repeat (3) @(negedge clk);
    m2_kick = 1'b1;
    cyc = 0;
    while (bus.ss_we !== 1'b1 && cyc < 60) begin @(negedge clk); cyc++; end
    check("tmo_hold_reached", {31'd0, bus.ss_we}, 1);
    wait_done(TMO + 40, cyc);
    check("tmo_hold_time", {31'd0, (cyc >= TMO - 2 && cyc <= TMO + 2)}, 1);
    check("tmo_hold_err", {31'd0, err}, 1);
    check("tmo_hold_we", {31'd0, bus.ss_we}, 0);
    @(negedge clk);
    check("tmo_hold_idle", {31'd0, busy}, 0);
    check("tmo_hold_nowrite", we_strobes, 0);
    check("tmo_hold_in_count", in_cnt, 1);
    in_q.delete();

    // ARM timeout: no M2 at all.
    clr_stats();
    do_start(1'b0);
    wait_done(TMO + 40, cyc);
    check("tmo_arm_time", {31'd0, (cyc >= TMO - 2 && cyc <= TMO + 2)}, 1);
    check("tmo_arm_err", {31'd0, err}, 1);
    @(negedge clk);
    check("tmo_arm_nobytes", out_q.size(), 0);

    // Reset while in HOLD.
    in_q.push_back(8'($urandom)); in_q.push_back(8'($urandom));
    clr_stats();
    do_start(1'b1);
    repeat (2) @(negedge clk);
    m2_kick = 1'b1;
    cyc = 0;
    while (bus.ss_we !== 1'b1 && cyc < 60) begin @(negedge clk); cyc++; end
    check("rsth_hold_reached", {31'd0, bus.ss_we}, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rsth_we",   {31'd0, bus.ss_we}, 0);
    check("rsth_act",  {31'd0, bus.ss_act}, 0);
    check("rsth_busy", {31'd0, busy}, 0);
    check("rsth_addr", {24'd0, bus.ss_addr}, 0);
    rst = 1'b0;
    in_q.delete();
    repeat (10) @(negedge clk);
    check("rsth_no_done", done_cnt, 0);

    // Fresh save after reset, random ready, 40-cycle stall at address 3.
    exp_q.delete();
    for (int i = 0; i <= LAST; i++) exp_q.push_back(mem[i]);
    m2_en = 1'b1; m2_per = $urandom_range(4, 9); rdy_mode = 2;
    clr_stats();
    do_start(1'b0);
    cyc = 0;
    while (!(bus.out_valid === 1'b1 && bus.ss_addr === 8'd3) && cyc < 300) begin
      @(negedge clk); cyc++;
    end
    check("stall_reached", {31'd0, bus.out_valid}, 1);
    prev_od = bus.out_data;
    m127 = bus.out_data;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.out_data !== m127 || err !== 1'b0 || busy !== 1'b1) bad++;
    end
    check("stall_held", bad, 0);
    check("stall_data", {24'd0, m127}, {24'd0, exp_q[3]});
    rdy_mode = 1;
    wait_done(3000, cyc);
    check("stall_err", {31'd0, err}, 0);
    @(negedge clk);
    check("stall_count", out_q.size(), LAST + 1);
    bad = 0;
    for (int i = 0; i <= LAST; i++) if (q_at(i) !== {24'd0, exp_q[i]}) bad++;
    check("stall_stream", bad, 0);
    check("stall_hold_rule", hold_viol, 0);
    check("stall_done_once", done_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
